// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding and default wide-word geometry for the BRAM arbiter
package bram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  localparam int DEF_ADDR_SIZE = 5;
  localparam int DEF_WIDTH = 256;
endpackage

// File: rtl/bram_arbiter_rr_picker.sv
// rr_picker: first eligible requester at or above rr_ptr, wrapping to 0
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IW = 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      grant,
  output logic               valid
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  assign dbl = {eligible, eligible} >> rr_ptr;
  assign rot = dbl[NUM_REQ-1:0];
  assign valid = |rot;
  // lowest set bit of the rotated mask is the offset from rr_ptr
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = IW'(k);
  end
  assign sum = {1'b0, rr_ptr} + {1'b0, off};
  assign grant = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin sharing of one bram_wrapper with single-cycle enables and a watchdog
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_REQ-1:0]           req_in,
  input  logic [NUM_REQ-1:0]           req_we_in,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr_in,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data_in,
  output logic [NUM_REQ-1:0]           done_out,
  output logic [WIDTH-1:0]             rd_data_out,
  output logic                         busy_out,
  output logic                         error_out,
  output logic [ADDR_SIZE-1:0]         addr_in,
  output logic [WIDTH-1:0]             data_in,
  output logic                         write_enable,
  output logic                         read_enable,
  input  logic [WIDTH-1:0]             data_out,
  input  logic                         finished_out
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_t state;
  logic [IW-1:0] g, rr_ptr, pick;
  logic pick_valid, we_q;
  logic [WW-1:0] wd_cnt;
  logic [NUM_REQ-1:0] eligible;
  // a requester is masked during its own done cycle so a stale level is not re-granted
  assign eligible = req_in & ~done_out;
  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .eligible(eligible),
    .rr_ptr(rr_ptr),
    .grant(pick),
    .valid(pick_valid)
  );
  // grant, issue a one-cycle enable, then wait for the wrapper or the watchdog
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      done_out <= '0;
      rd_data_out <= '0;
      busy_out <= 1'b0;
      error_out <= 1'b0;
      addr_in <= '0;
      data_in <= '0;
      write_enable <= 1'b0;
      read_enable <= 1'b0;
      rr_ptr <= '0;
      wd_cnt <= '0;
      g <= '0;
      we_q <= 1'b0;
    end else begin
      done_out <= '0;
      case (state)
        IDLE: if (pick_valid) begin
          g <= pick;
          we_q <= req_we_in[pick];
          addr_in <= req_addr_in[pick*ADDR_SIZE +: ADDR_SIZE];
          data_in <= req_data_in[pick*WIDTH +: WIDTH];
          write_enable <= req_we_in[pick];
          read_enable <= ~req_we_in[pick];
          busy_out <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          write_enable <= 1'b0;
          read_enable <= 1'b0;
          wd_cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (finished_out || wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
          if (finished_out && !we_q) rd_data_out <= data_out;
          if (!finished_out) error_out <= 1'b1;
          done_out <= NUM_REQ'(1) << g;
          rr_ptr <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
          busy_out <= 1'b0;
          state <= IDLE;
        end else wd_cnt <= wd_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed checks of arbitration, latency, watchdog and reset with a behavioural wrapper
module tb_bram_arbiter;
  localparam int LAT = 3;
  localparam logic [255:0] W = 256'hBEAD0000BE0011228888888888888888BEAD0000BE0011228888888888888888;
  localparam logic [255:0] D12 = {8{32'hCAFEF00D}};
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [1:0] req_in = '0, req_we_in = '0, done_out;
  logic [9:0] req_addr_in = '0;
  logic [511:0] req_data_in = '0;
  logic [255:0] rd_data_out, data_in, data_out;
  logic busy_out, error_out, write_enable, read_enable, finished_out;
  logic [4:0] addr_in;
  int vectors = 0, miscompares = 0;
  logic [255:0] mem [0:31];
  logic fin_m = 1'b0, spur = 1'b0, stub = 1'b0, busy_m = 1'b0, lat_we = 1'b0;
  logic [4:0] lat_addr = '0;
  logic [255:0] lat_data = '0;
  int cnt = 0;

  bram_arbiter #(.NUM_REQ(2), .ADDR_SIZE(5), .WIDTH(256), .TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .req_we_in(req_we_in),
    .req_addr_in(req_addr_in), .req_data_in(req_data_in), .done_out(done_out),
    .rd_data_out(rd_data_out), .busy_out(busy_out), .error_out(error_out),
    .addr_in(addr_in), .data_in(data_in), .write_enable(write_enable),
    .read_enable(read_enable), .data_out(data_out), .finished_out(finished_out)
  );

  always #5 clk_in = ~clk_in;
  assign finished_out = fin_m | spur;

  // wrapper model: finished pulses LAT edges after the enable is seen; stub never finishes
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fin_m <= 1'b0;
      busy_m <= 1'b0;
      cnt <= 0;
      data_out <= '0;
    end else begin
      fin_m <= 1'b0;
      if (write_enable || read_enable) begin
        busy_m <= 1'b1;
        cnt <= 0;
        lat_we <= write_enable;
        lat_addr <= addr_in;
        lat_data <= data_in;
      end else if (busy_m) begin
        if (cnt == LAT - 1) begin
          busy_m <= 1'b0;
          if (!stub) begin
            fin_m <= 1'b1;
            if (lat_we) mem[lat_addr] <= lat_data;
            else data_out <= mem[lat_addr];
          end
        end else cnt <= cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input int i, input logic we, input logic [4:0] a, input logic [255:0] d,
                     output int lat, output int ens, output int dones,
                     output logic [1:0] dval, output logic [255:0] rd);
    req_we_in[i] = we;
    req_addr_in[i*5 +: 5] = a;
    req_data_in[i*256 +: 256] = d;
    req_in[i] = 1'b1;
    lat = 0; ens = 0; dones = 0; dval = '0; rd = '0;
    while (lat < 64 && done_out[i] !== 1'b1) begin
      @(negedge clk_in);
      lat++;
      if (we ? write_enable : read_enable) ens++;
    end
    if (done_out[i] === 1'b1) begin
      dones = 1;
      dval = done_out;
      rd = rd_data_out;
    end
    req_in[i] = 1'b0;
    repeat (2) begin
      @(negedge clk_in);
      if (done_out[i] === 1'b1) dones++;
      if (write_enable || read_enable) ens++;
    end
  endtask

  initial begin
    int lat, ens, dones, n, issued, bad;
    logic [1:0] dval;
    logic [255:0] rd, rd1;
    int order [0:5];
    #3;
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_err", error_out, 0);
    check("rst_en", {write_enable, read_enable}, 0);
    check("rst_rd", rd_data_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    txn(0, 1'b1, 5'd0, W, lat, ens, dones, dval, rd);
    check("wr_lat", lat, 6);
    check("wr_we_cycles", ens, 1);
    check("wr_done_pulses", dones, 1);
    check("wr_done_val", dval, 2'b01);
    check("wr_rd_unchanged", rd, 0);

    txn(0, 1'b0, 5'd0, '0, lat, ens, dones, dval, rd);
    check("rd_lat", lat, 6);
    check("rd_re_cycles", ens, 1);
    check("rd_done_pulses", dones, 1);
    check("rd_data", rd, W);

    txn(1, 1'b0, 5'd0, '0, lat, ens, dones, dval, rd);
    check("rd1_done_val", dval, 2'b10);
    check("rd1_data", rd, W);

    req_we_in = 2'b01;
    req_addr_in = {5'd0, 5'd12};
    req_data_in = {256'h0, D12};
    req_in = 2'b11;
    n = 0; bad = 0; rd1 = '0;
    for (int c = 0; c < 100 && n < 2; c++) begin
      @(negedge clk_in);
      if (done_out == 2'b11) bad++;
      for (int i = 0; i < 2; i++)
        if (done_out[i] === 1'b1) begin
          order[n] = i;
          n++;
          req_in[i] = 1'b0;
          if (i == 1) rd1 = rd_data_out;
        end
    end
    check("cont_count", n, 2);
    check("cont_first", order[0], 0);
    check("cont_second", order[1], 1);
    check("cont_onehot", bad, 0);
    check("cont_rd1", rd1, W);
    repeat (2) @(negedge clk_in);

    req_we_in = 2'b00;
    req_addr_in = '0;
    req_in = 2'b11;
    issued = 2; n = 0; bad = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk_in);
      if (done_out == 2'b11) bad++;
      for (int i = 0; i < 2; i++)
        if (done_out[i] === 1'b1) begin
          order[n] = i;
          n++;
          req_in[i] = 1'b0;
        end else if (!req_in[i] && issued < 6) begin
          req_in[i] = 1'b1;
          issued++;
        end
    end
    check("fair_count", n, 6);
    for (int k = 0; k < 6; k++) check($sformatf("fair_grant%0d", k), order[k], k % 2);
    check("fair_onehot", bad, 0);
    repeat (2) @(negedge clk_in);

    spur = 1'b1;
    @(negedge clk_in);
    spur = 1'b0;
    check("spur_busy", busy_out, 0);
    @(negedge clk_in);
    check("spur_done", done_out, 0);
    check("spur_busy2", busy_out, 0);

    stub = 1'b1;
    txn(0, 1'b0, 5'd12, '0, lat, ens, dones, dval, rd);
    stub = 1'b0;
    check("wd_lat", lat, 10);
    check("wd_done_val", dval, 2'b01);
    check("wd_rd_unchanged", rd, W);
    check("wd_error", error_out, 1);

    txn(1, 1'b0, 5'd12, '0, lat, ens, dones, dval, rd);
    check("post_wd_lat", lat, 6);
    check("post_wd_rd", rd, D12);
    check("wd_error_sticky", error_out, 1);

    req_we_in[0] = 1'b0;
    req_addr_in[4:0] = 5'd0;
    req_in[0] = 1'b1;
    repeat (3) @(negedge clk_in);
    check("mid_busy", busy_out, 1);
    #2;
    rst_in = 1'b1;
    req_in = '0;
    #1;
    check("mrst_busy", busy_out, 0);
    check("mrst_err", error_out, 0);
    check("mrst_addr", addr_in, 0);
    check("mrst_rd", rd_data_out, 0);
    check("mrst_en", {write_enable, read_enable, done_out}, 0);
    bad = 0;
    repeat (2) begin
      @(negedge clk_in);
      if (done_out !== 2'b00) bad++;
    end
    rst_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (done_out !== 2'b00) bad++;
    end
    check("mrst_no_done", bad, 0);
    txn(0, 1'b0, 5'd12, '0, lat, ens, dones, dval, rd);
    check("mrst_after_lat", lat, 6);
    check("mrst_after_rd", rd, D12);
    check("mrst_after_done", dval, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
